// File: rtl/conv_window_gen_pkg.sv
// Shared constants, the window-width helper and the FSM state type for the
// sliding-window generator.
package conv_window_gen_pkg;

  localparam int IMG_WIDTH_DEF   = 28;
  localparam int IMG_HEIGHT_DEF  = 28;
  localparam int FILTER_SIZE_DEF = 5;
  localparam int DATA_BITS_DEF   = 8;

  // Width of one packed FILTER_SIZE x FILTER_SIZE window.
  function automatic int win_bits(input int filter_size, input int data_bits);
    return filter_size * filter_size * data_bits;
  endfunction

  localparam int WIN_BITS_DEF = FILTER_SIZE_DEF * FILTER_SIZE_DEF * DATA_BITS_DEF;

  // FILL: not enough rows buffered yet; RUN: windows may be emitted.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_e;

endpackage

// File: rtl/conv_line_buffer.sv
// Single-row FIFO of depth DEPTH built from a RAM and a wrap-around pointer.
// On every shift the word written DEPTH shifts ago is presented on dout_o and
// replaced by din_i, so dout_o is the pixel one row above the incoming pixel.
module conv_line_buffer
  import conv_window_gen_pkg::*;
#(
  parameter int DEPTH     = IMG_WIDTH_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en_i,
  input  logic [DATA_BITS-1:0] din_i,
  output logic [DATA_BITS-1:0] dout_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     ptr_d;

  // Next pointer position, wrapping after the last column.
  always_comb begin
    ptr_d = ptr_q;
    if (shift_en_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // Pointer register; realigns with column 0 whenever the frame restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // RAM write of the incoming pixel into the slot being vacated.
  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      mem[ptr_q] <= din_i;
    end
  end

  // Oldest word is read at the current pointer, ahead of being overwritten.
  assign dout_o = mem[ptr_q];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming FILTER_SIZE x FILTER_SIZE window generator. Buffers FILTER_SIZE-1
// rows in cascaded line buffers, keeps the live window in a register array and
// emits a valid strobe only for windows lying fully inside the image.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF,
  parameter int FILTER_SIZE = FILTER_SIZE_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_val,
  input  logic [DATA_BITS-1:0]                              pixel_in,
  output logic [win_bits(FILTER_SIZE, DATA_BITS)-1:0]       data_out,
  output logic                                              out_val,
  output logic                                              frame_done
);

  localparam int F     = FILTER_SIZE;
  localparam int NLB   = FILTER_SIZE - 1;
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  logic [DATA_BITS-1:0] lb_din  [NLB];
  logic [DATA_BITS-1:0] lb_dout [NLB];
  logic [DATA_BITS-1:0] col_pix [F];

  logic [DATA_BITS-1:0] win_q [F][F];
  logic [DATA_BITS-1:0] win_d [F][F];

  win_state_e       state_q, state_d;
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic             out_val_q, out_val_d;
  logic             frame_done_q, frame_done_d;

  // Line buffer cascade: buffer 0 takes the new pixel, buffer k takes the
  // output of buffer k-1, so buffer k emits the pixel k+1 rows above.
  generate
    for (genvar gi = 0; gi < NLB; gi++) begin : g_lb
      if (gi == 0) begin : g_first
        assign lb_din[gi] = pixel_in;
      end else begin : g_chain
        assign lb_din[gi] = lb_dout[gi-1];
      end
      conv_line_buffer #(
        .DEPTH     (IMG_WIDTH),
        .DATA_BITS (DATA_BITS)
      ) u_line_buffer (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (in_val),
        .din_i      (lb_din[gi]),
        .dout_o     (lb_dout[gi])
      );
    end
  endgenerate

  // Incoming column, top (oldest) row first, current pixel at the bottom.
  generate
    for (genvar gi = 0; gi < F; gi++) begin : g_col
      if (gi == F - 1) begin : g_bottom
        assign col_pix[gi] = pixel_in;
      end else begin : g_upper
        assign col_pix[gi] = lb_dout[F-2-gi];
      end
    end
  endgenerate

  // Window shift: every column moves one left, new column enters on the right.
  generate
    for (genvar gi = 0; gi < F; gi++) begin : g_win_row
      for (genvar gc = 0; gc < F; gc++) begin : g_win_col
        if (gc == F - 1) begin : g_new
          assign win_d[gi][gc] = in_val ? col_pix[gi] : win_q[gi][gc];
        end else begin : g_shift
          assign win_d[gi][gc] = in_val ? win_q[gi][gc+1] : win_q[gi][gc];
        end
        assign data_out[(gi*F+gc)*DATA_BITS +: DATA_BITS] = win_q[gi][gc];
      end
    end
  endgenerate

  // Window register array; cleared so data_out reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < F; r++) begin
        for (int c = 0; c < F; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      win_q <= win_d;
    end
  end

  // Next state, counters and strobes; only accepted pixels advance anything.
  always_comb begin
    logic last_col;
    logic last_row;
    state_d      = state_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    out_val_d    = 1'b0;
    frame_done_d = 1'b0;
    last_col     = (col_cnt_q == COL_W'(IMG_WIDTH - 1));
    last_row     = (row_cnt_q == ROW_W'(IMG_HEIGHT - 1));
    if (in_val) begin
      col_cnt_d = last_col ? '0 : col_cnt_q + 1'b1;
      if (last_col) begin
        row_cnt_d = last_row ? '0 : row_cnt_q + 1'b1;
      end
      frame_done_d = last_col && last_row;
      case (state_q)
        FILL: begin
          // The last pixel of row F-2 completes the line buffer fill.
          if (last_col && (row_cnt_q == ROW_W'(F - 2))) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // Leftmost F-1 columns would form windows wrapping across rows.
          out_val_d = (col_cnt_q >= COL_W'(F - 1));
          if (last_col && last_row) begin
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State, counter and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      out_val_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      out_val_q    <= out_val_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_val    = out_val_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: gapless, back-to-back, gapped and
// mid-frame-reset frames, every output cycle compared against a window model.
module tb_conv_window_gen;
  import conv_window_gen_pkg::*;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int F  = 5;
  localparam int DB = 8;
  localparam int WB = F * F * DB;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_val;
  logic [DB-1:0] pixel_in;
  logic [WB-1:0] data_out;
  logic          out_val;
  logic          frame_done;

  always #5 clk = ~clk;

  conv_window_gen #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .FILTER_SIZE (F),
    .DATA_BITS   (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_val     (in_val),
    .pixel_in   (pixel_in),
    .data_out   (data_out),
    .out_val    (out_val),
    .frame_done (frame_done)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int win_cnt  = 0;
  int done_cnt = 0;

  // Expectation for the outputs produced by the most recent drive.
  logic          exp_val   = 1'b0;
  logic          exp_done  = 1'b0;
  logic          prev_acc  = 1'b0;
  logic          known     = 1'b0;
  logic [WB-1:0] exp_data  = '0;
  logic [WB-1:0] hold_data = '0;
  int            exp_r     = 0;
  int            exp_c     = 0;
  int            exp_off   = 0;

  task automatic check_eq(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [DB-1:0] pix(input int r, input int c, input int off);
    return DB'((r * W + c + off) % 256);
  endfunction

  function automatic logic [WB-1:0] exp_win(input int r0, input int c0, input int off);
    logic [WB-1:0] w = '0;
    for (int rr = 0; rr < F; rr++)
      for (int cc = 0; cc < F; cc++)
        w[(rr*F+cc)*DB +: DB] = pix(r0 - F + 1 + rr, c0 - F + 1 + cc, off);
    return w;
  endfunction

  function automatic logic [WB-1:0] el(input int i);
    return WB'(data_out[i*DB +: DB]);
  endfunction

  // Check outputs of the previous drive, then drive one cycle of input.
  task automatic step(input bit v, input int r, input int c, input int off);
    @(negedge clk);
    check_eq("out_val", WB'(out_val), WB'(exp_val));
    check_eq("frame_done", WB'(frame_done), WB'(exp_done));
    if (exp_val) check_eq("window", data_out, exp_data);
    else if (!prev_acc && known) check_eq("hold", data_out, hold_data);
    if (out_val) win_cnt++;
    if (frame_done) done_cnt++;
    if (exp_val && exp_r == 4 && exp_c == 4) begin
      check_eq("first_e0", el(0), WB'((0 + exp_off) % 256));
      check_eq("first_e12", el(12), WB'((58 + exp_off) % 256));
      check_eq("first_e24", el(24), WB'((116 + exp_off) % 256));
    end
    if (exp_val && exp_r == 6 && exp_c == 4)
      check_eq("row_edge_e0", el(0), WB'((56 + exp_off) % 256));
    if (exp_done)
      check_eq("last_e24", el(24), WB'((15 + exp_off) % 256));

    in_val   = v;
    pixel_in = v ? pix(r, c, off) : DB'($urandom);
    exp_val  = v && r >= F - 1 && c >= F - 1;
    exp_done = v && r == H - 1 && c == W - 1;
    exp_r    = r;
    exp_c    = c;
    exp_off  = off;
    prev_acc = v;
    if (exp_val) begin
      exp_data  = exp_win(r, c, off);
      hold_data = exp_data;
      known     = 1'b1;
    end else if (v) begin
      known = 1'b0;
    end
  endtask

  task automatic run_frame(input int off, input int gap_pct);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) step(1'b0, 0, 0, off);
        step(1'b1, r, c, off);
      end
  endtask

  task automatic check_counts(input string tag, input int w0, input int d0, input int nfr);
    step(1'b0, 0, 0, 0);
    check_eq({tag, "_windows"}, WB'(win_cnt - w0), WB'(576 * nfr));
    check_eq({tag, "_frame_done"}, WB'(done_cnt - d0), WB'(nfr));
    $display("%s: windows=%0d frame_done=%0d", tag, win_cnt - w0, done_cnt - d0);
  endtask

  initial begin
    int w0;
    int d0;
    bit stop;
    rst      = 1'b1;
    in_val   = 1'b0;
    pixel_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_val", WB'(out_val), '0);
    check_eq("rst_frame_done", WB'(frame_done), '0);
    check_eq("rst_data_out", data_out, '0);
    rst       = 1'b0;
    known     = 1'b1;
    hold_data = '0;

    // Gapless single frame.
    w0 = win_cnt; d0 = done_cnt;
    run_frame(0, 0);
    check_counts("gapless", w0, d0, 1);

    // Two back-to-back frames, the second offset by 100.
    w0 = win_cnt; d0 = done_cnt;
    run_frame(0, 0);
    run_frame(100, 0);
    check_counts("back_to_back", w0, d0, 2);

    // About 40% idle cycles.
    w0 = win_cnt; d0 = done_cnt;
    run_frame(0, 40);
    check_counts("gapped", w0, d0, 1);

    // Partial frame up to (10,10), then asynchronous reset.
    stop = 1'b0;
    for (int r = 0; r < H && !stop; r++)
      for (int c = 0; c < W && !stop; c++) begin
        step(1'b1, r, c, 0);
        stop = (r == 10 && c == 10);
      end
    @(posedge clk);
    #1;
    check_eq("pre_rst_out_val", WB'(out_val), WB'(1'b1));
    #1;
    rst    = 1'b1;
    in_val = 1'b0;
    #1;
    check_eq("async_rst_out_val", WB'(out_val), '0);
    check_eq("async_rst_data_out", data_out, '0);
    @(negedge clk);
    rst       = 1'b0;
    exp_val   = 1'b0;
    exp_done  = 1'b0;
    prev_acc  = 1'b0;
    known     = 1'b1;
    hold_data = '0;
    $display("reset at (10,10) applied");

    w0 = win_cnt; d0 = done_cnt;
    run_frame(0, 0);
    check_counts("after_reset", w0, d0, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming sliding-window generator directly upstream of the convolution calculator. Accepts one unsigned pixel per cycle in raster order. Buffers FILTER_SIZE-1 image rows in line buffers and emits each complete FILTER_SIZE x FILTER_SIZE window with a valid strobe. The window is packed exactly as the conv stage's data_in expects. Convolution is "valid" only: no padding, stride 1.

Parameters:
IMG_WIDTH, 28, pixels per image row (>= FILTER_SIZE)
IMG_HEIGHT, 28, rows per frame (>= FILTER_SIZE)
FILTER_SIZE, 5, window edge length (>= 2)
DATA_BITS, 8, unsigned pixel width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
in_val  in  1  pixel_in valid this cycle
pixel_in  in  DATA_BITS  unsigned pixel, raster order (row-major, left to right)
data_out  out  FILTER_SIZE*FILTER_SIZE*DATA_BITS  packed window
out_val  out  1  data_out holds a complete window this cycle
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (async assert, any cycle): col_cnt=0, row_cnt=0, state=FILL, out_val=0, frame_done=0, data_out=0, all window registers=0. Line buffer RAM contents are don't-care. Any partial frame is discarded; the next accepted pixel is (0,0).
- Only cycles with in_val=1 advance anything. With in_val=0, all state, data_out and counters hold, and out_val/frame_done are 0. Gaps of any length are legal.
- Counters: col_cnt 0..IMG_WIDTH-1 wraps to 0 and increments row_cnt. row_cnt 0..IMG_HEIGHT-1 wraps to 0 at end of frame.
- Line buffers: FILTER_SIZE-1 row FIFOs of depth IMG_WIDTH, cascaded. On each accepted pixel, column c of the current window = {lb[F-2] out, ..., lb[0] out, pixel_in}, ordered oldest row to newest. Window registers shift one column left.
- Packing: element i = r*FILTER_SIZE + c occupies data_out[i*DATA_BITS +: DATA_BITS]. r=0 is the top (oldest) row; c=0 is the leftmost (oldest) column. Element FILTER_SIZE^2-1 is the pixel just accepted.
- Latency: when pixel (R,C) is accepted at edge N, data_out/out_val are registered and valid in the cycle after edge N. That window has (R,C) at bottom-right.
- out_val=1 iff the accepted pixel has R >= FILTER_SIZE-1 and C >= FILTER_SIZE-1. Columns 0..F-2 of every row are suppressed (no cross-row wrap windows).
- Windows per frame: (IMG_WIDTH-F+1)*(IMG_HEIGHT-F+1), i.e. 576 at defaults.
- FSM, advancing only on accepted pixels:
  - FILL: row_cnt < F-1; out_val held 0. Moves to RUN when pixel (F-2, IMG_WIDTH-1) is accepted.
  - RUN: out_val per the column rule above.
  - At pixel (IMG_HEIGHT-1, IMG_WIDTH-1): frame_done=1 in the same output cycle as that pixel's out_val. State returns to FILL and counters wrap.
- Back-to-back frames with no gap are legal. Stale rows from the previous frame are never emitted, because FILL masks them.
- No backpressure. The downstream stage is combinational plus a register and always accepts.

Decomposition:
- Shared package: FILTER_SIZE/DATA_BITS defaults, a window-width constant (FILTER_SIZE^2*DATA_BITS), and a state enum (FILL, RUN).
- One sub-module, conv_line_buffer: a single-row FIFO of depth IMG_WIDTH with a shift-enable. It is instantiated FILTER_SIZE-1 times in a cascade. Implement it as a RAM plus a wrap-around pointer, not as a shift chain.

Test Plan:
1. Defaults; pixel(R,C)=(R*28+C) mod 256; in_val=1 continuous. First out_val comes 1 cycle after accepting (4,4). Element 0 = 0, element 12 = pixel(2,2) = 58, element 24 = pixel(4,4) = 116.
2. Full frame count: exactly 576 out_val pulses and 1 frame_done. frame_done coincides with the window whose element 24 = pixel(27,27) = (783 mod 256) = 15.
3. Row-edge check: after accepting (5,27), the next out_val follows (6,4), not (6,0..3). Its element 0 = pixel(2,0) = 56.
4. Random in_val gaps (about 40% idle) with the stimulus from scenario 1: the window sequence is identical to the gapless run; out_val=0 on every idle cycle and data_out holds.
5. Back-to-back frames, frame 2 pixels = frame-1 value + 100: the first frame-2 window appears after accepting (4,4) of frame 2. Its element 0 = 100, and no window is emitted during frame-2 rows 0..3.
6. Assert rst mid-RUN at pixel (10,10): out_val drops to 0 asynchronously. Restarting the frame reproduces scenario 1 exactly, with the first window after (4,4).
